// File: rtl/regfile_dump_reader.sv
// Walks the regfile debug port and streams each register as a 5-byte frame {addr, data[31:24..7:0]}.
// Latency: first byte valid 2 edges after start acceptance; 6 cycles per register when byte_ready stays high.
// Backpressure: byte_data/byte_valid hold until accepted; the sweep stalls on a low byte_ready.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_hold;
    logic [2:0]          r_idx;
    logic [7:0]          r_byte;
    logic                r_vld;
    logic                r_busy;
    logic                r_done;

    state_t              w_state;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_hold;
    logic [2:0]          w_idx;
    logic [7:0]          w_byte;
    logic                w_vld;
    logic                w_busy;
    logic                w_done;
    logic                w_accept;

    assign w_accept = r_vld & byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_hold  <= '0;
            r_idx   <= '0;
            r_byte  <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_addr  <= w_addr;
            r_hold  <= w_hold;
            r_idx   <= w_idx;
            r_byte  <= w_byte;
            r_vld   <= w_vld;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_addr  = r_addr;
        w_hold  = r_hold;
        w_idx   = r_idx;
        w_byte  = r_byte;
        w_vld   = r_vld;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state = FETCH;
                    w_addr  = '0;
                    w_busy  = 1'b1;
                end
            end

            // The register is snapshotted here; later writes never reach this frame.
            FETCH: begin
                w_hold  = debug_data;
                w_idx   = 3'd0;
                w_byte  = 8'(r_addr);
                w_vld   = 1'b1;
                w_state = SEND;
            end

            SEND: begin
                if (w_accept) begin
                    case (r_idx)
                        3'd0: begin
                            w_byte = r_hold[31:24];
                            w_idx  = 3'd1;
                        end
                        3'd1: begin
                            w_byte = r_hold[23:16];
                            w_idx  = 3'd2;
                        end
                        3'd2: begin
                            w_byte = r_hold[15:8];
                            w_idx  = 3'd3;
                        end
                        3'd3: begin
                            w_byte = r_hold[7:0];
                            w_idx  = 3'd4;
                        end
                        default: begin
                            w_vld = 1'b0;
                            if (r_addr == LAST_ADDR) begin
                                w_state = IDLE;
                                w_addr  = '0;
                                w_busy  = 1'b0;
                                w_done  = 1'b1;
                            end else begin
                                w_state = FETCH;
                                w_addr  = r_addr + 1'b1;
                            end
                        end
                    endcase
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign debug_addr = r_addr;
    assign byte_data  = r_byte;
    assign byte_valid = r_vld;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised bench for regfile_dump_reader: a frame-level model fills byte queues, negedge monitors drain them.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        busy;
    logic        done;

    logic        start4 = 1'b0;
    logic [1:0]  addr4;
    logic [31:0] data4;
    logic [7:0]  byte4;
    logic        vld4;
    logic        busy4;
    logic        done4;

    logic [31:0] regs [32];
    logic [31:0] regs4 [4];
    logic [31:0] exp_val [32];

    logic [7:0]  q [$];
    logic [7:0]  q4 [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rmode = 0;
    int rx_cnt = 0, done_cnt = 0, busy_cyc = 0;
    int rx4 = 0, done4_cnt = 0, busy4_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign debug_data = (debug_addr == 5'd0) ? 32'h0 : regs[debug_addr];
    assign data4      = (addr4 == 2'd0) ? 32'h0 : regs4[addr4];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .debug_addr(debug_addr), .debug_data(debug_data),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done)
    );

    regfile_dump_reader #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .debug_addr(addr4), .debug_data(data4),
        .byte_data(byte4), .byte_valid(vld4), .byte_ready(1'b1),
        .busy(busy4), .done(done4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ready pattern driver: 0 = always high, 1 = one cycle in three, 2 = random.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = (phase == 0);
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
            phase = (phase + 1) % 3;
        end
    end

    // Scoreboard monitor for the 32-register instance.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_dat = 8'h0;
        logic       prev_busy = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_hold", 64'(byte_valid), 64'd1);
                    chk("stall_data_hold", 64'(byte_data), 64'(prev_dat));
                end
                if (byte_valid && byte_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_byte", 64'(byte_data), 64'hFFFF);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("byte%0d", rx_cnt), 64'(byte_data), 64'(e));
                    end
                    rx_cnt++;
                end
                prev_stall = byte_valid && !byte_ready;
                prev_dat   = byte_data;
                if (busy && !prev_busy) busy_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    chk("done_busy_low", 64'(busy), 64'd0);
                    if (rmode == 0) chk("done_latency", 64'(cyc - busy_cyc), 64'd192);
                end
                prev_busy = busy;
            end
        end
    end

    // Monitor for the 4-register instance (ready tied high).
    initial begin
        logic       prev_busy = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (vld4) begin
                    if (q4.size() == 0) begin
                        chk("n4_unexpected_byte", 64'(byte4), 64'hFFFF);
                    end else begin
                        e = q4.pop_front();
                        chk($sformatf("n4_byte%0d", rx4), 64'(byte4), 64'(e));
                    end
                    rx4++;
                end
                if (busy4 && !prev_busy) busy4_cyc = cyc;
                if (done4) begin
                    done4_cnt++;
                    chk("n4_done_latency", 64'(cyc - busy4_cyc), 64'd24);
                end
                prev_busy = busy4;
            end
        end
    end

    task automatic push_frames(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] v;
            v = (k == 0) ? 32'h0 : exp_val[k];
            q.push_back(8'(k));
            for (int b = 3; b >= 0; b--) q.push_back(v[8*b +: 8]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_dump(input int mode, input bit repulse);
        rmode    = mode;
        rx_cnt   = 0;
        done_cnt = 0;
        push_frames(32);
        pulse_start();
        if (repulse) begin
            for (int i = 0; i < 3000 && rx_cnt < 40; i++) @(posedge clk);
            chk("repulse_reached", 64'(rx_cnt >= 40), 64'd1);
            pulse_start();
        end
        for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
        chk("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (12) @(posedge clk);
        #2;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("byte_count", 64'(rx_cnt), 64'd160);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_addr", 64'(debug_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        for (int k = 0; k < 4; k++)  regs4[k] = 32'h0;
        #1;
        chk("rst_valid", 64'(byte_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_addr", 64'(debug_addr), 64'd0);
        chk("rst_data", 64'(byte_data), 64'd0);
        chk("rst4_valid", 64'(vld4), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Sparse regfile, ready high.
        regs[1] = 32'h0000_0001;
        regs[5] = 32'hDEAD_BEEF;
        for (int k = 0; k < 32; k++) exp_val[k] = regs[k];
        run_dump(0, 1'b0);

        // Same contents, ready one-in-three.
        run_dump(1, 1'b0);

        // Random contents, random ready, start re-pulsed mid-dump.
        for (int k = 1; k < 32; k++) regs[k] = $urandom;
        for (int k = 0; k < 32; k++) exp_val[k] = regs[k];
        run_dump(2, 1'b1);

        // Writes landing after r7's snapshot but before r9's.
        for (int k = 1; k < 32; k++) regs[k] = $urandom;
        regs[7] = 32'h0;
        regs[9] = 32'h0;
        for (int k = 0; k < 32; k++) exp_val[k] = regs[k];
        exp_val[9] = 32'h1234_5678;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (byte_valid && debug_addr == 5'd7) break;
                end
                regs[7] = 32'h1234_5678;
                regs[9] = 32'h1234_5678;
            end
        join_none
        run_dump(0, 1'b0);

        // Abort mid-frame with reset, then a clean dump.
        rmode    = 2;
        rx_cnt   = 0;
        done_cnt = 0;
        for (int k = 0; k < 32; k++) exp_val[k] = regs[k];
        push_frames(32);
        pulse_start();
        for (int i = 0; i < 3000 && rx_cnt < 17; i++) @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (byte_valid) break;
        end
        chk("pre_rst_valid", 64'(byte_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(byte_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_addr", 64'(debug_addr), 64'd0);
        chk("abort_data", 64'(byte_data), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        run_dump(0, 1'b0);

        // Four-register instance.
        for (int k = 1; k < 4; k++) regs4[k] = $urandom;
        for (int k = 0; k < 4; k++) begin
            q4.push_back(8'(k));
            for (int b = 3; b >= 0; b--) q4.push_back(regs4[k][8*b +: 8]);
        end
        @(posedge clk);
        #1 start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int i = 0; i < 200 && done4_cnt == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        chk("n4_done_pulses", 64'(done4_cnt), 64'd1);
        chk("n4_byte_count", 64'(rx4), 64'd20);
        chk("n4_queue_empty", 64'(q4.size()), 64'd0);
        chk("n4_idle_busy", 64'(busy4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
